// File: rtl/wheel_cmd_sequencer_if.sv
// Command handshake bundle between the SoC register bank (master) and the
// wheel command sequencer (slave).
interface wheel_cmd_if #(
    parameter int DUR_W = 16
);
    logic             valid;
    logic             ready;
    logic [1:0]       dir;
    logic [DUR_W-1:0] dur;

    modport master (output valid, dir, dur, input ready);
    modport slave  (input valid, dir, dur, output ready);
endinterface

// File: rtl/wheel_cmd_sequencer.sv
// Timed wheel command sequencer: FIFO of {dir, dur} commands played back as a
// registered 2-bit wheel code. Optional macro WHEEL_SEQ_BUMPER_EN adds bumper/bumped.
module wheel_cmd_sequencer #(
    parameter int DEPTH    = 4,
    parameter int DUR_W    = 16,
    parameter int PRESCALE = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    wheel_cmd_if.slave             cmd,
    input  logic                   abort,
    output logic [1:0]             state,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] level
`ifdef WHEEL_SEQ_BUMPER_EN
   ,input  logic                   bumper,
    output logic                   bumped
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
    localparam logic [1:0]    STOP    = 2'b11;

    typedef struct packed {
        logic [1:0]       dir;
        logic [DUR_W-1:0] dur;
    } entry_t;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} fsm_t;

    entry_t           mem [DEPTH];
    entry_t           head_reg;
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [AW:0]      count_reg;
    fsm_t             fsm_reg;
    logic [PW-1:0]    presc_reg;
    logic [DUR_W-1:0] ticks_reg;
    logic [1:0]       state_reg;
    logic             busy_reg, done_reg;
    logic             full, kill, bump, push, pop;

`ifdef WHEEL_SEQ_BUMPER_EN
    logic bumped_reg;
    assign bump   = bumper && (state_reg == 2'b00);
    assign bumped = bumped_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            bumped_reg <= 1'b0;
        end else if (bump) begin
            bumped_reg <= 1'b1;
        end else if (push) begin
            bumped_reg <= 1'b0;
        end
    end
`else
    assign bump = 1'b0;
`endif

    assign kill      = abort || bump;
    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign cmd.ready = !full && !kill && !rst;
    assign push      = cmd.valid && cmd.ready;
    assign pop       = (fsm_reg == LOAD);
    assign rd_ptr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

    assign state = state_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign level = count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= '{dir: cmd.dir, dur: cmd.dur};
        end
    end

    // Prefetch the entry LOAD will consume: LOAD is only entered when that
    // entry was already stored before the entering edge, so head_reg is valid.
    always_ff @(posedge clk) begin
        head_reg <= mem[rd_ptr_next];
    end

    always_ff @(posedge clk) begin
        if (rst || kill) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg <= rd_ptr_next;
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_reg   <= IDLE;
            presc_reg <= '0;
            ticks_reg <= '0;
            state_reg <= STOP;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else if (kill) begin
            fsm_reg   <= IDLE;
            state_reg <= STOP;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (fsm_reg)
                IDLE: begin
                    if (count_reg != '0) begin
                        fsm_reg <= LOAD;
                    end
                end
                LOAD: begin
                    presc_reg <= '0;
                    ticks_reg <= head_reg.dur;
                    if (head_reg.dur == '0) begin
                        done_reg <= 1'b1;
                        fsm_reg  <= (count_reg > (AW+1)'(1)) ? LOAD : IDLE;
                    end else begin
                        state_reg <= head_reg.dir;
                        busy_reg  <= 1'b1;
                        fsm_reg   <= RUN;
                    end
                end
                RUN: begin
                    if (presc_reg == PS_LAST) begin
                        presc_reg <= '0;
                        ticks_reg <= ticks_reg - 1'b1;
                        if (ticks_reg == DUR_W'(1)) begin
                            state_reg <= STOP;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            fsm_reg   <= (count_reg != '0) ? LOAD : IDLE;
                        end
                    end else begin
                        presc_reg <= presc_reg + 1'b1;
                    end
                end
                default: fsm_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wheel_cmd_sequencer.sv
// Self-checking bench for wheel_cmd_sequencer: directed steps plus random traffic,
// compared every cycle against a queue-based model that counts whole-command cycles.
module tb_wheel_cmd_sequencer;
    localparam int DEPTH    = 4;
    localparam int DUR_W    = 8;
    localparam int PRESCALE = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   abort = 1'b0;
    logic [1:0]             state;
    logic                   busy, done;
    logic [$clog2(DEPTH):0] level;
`ifdef WHEEL_SEQ_BUMPER_EN
    logic                   bumper = 1'b0;
    logic                   bumped;
`endif

    wheel_cmd_if #(.DUR_W(DUR_W)) cmd_bus ();

    wheel_cmd_sequencer #(
        .DEPTH   (DEPTH),
        .DUR_W   (DUR_W),
        .PRESCALE(PRESCALE)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .cmd   (cmd_bus.slave),
        .abort (abort),
        .state (state),
        .busy  (busy),
        .done  (done),
        .level (level)
`ifdef WHEEL_SEQ_BUMPER_EN
       ,.bumper(bumper),
        .bumped(bumped)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] dir;
        int         dur;
    } cmd_t;

    // Model: pending commands, what the player is doing, cycles left in the command
    cmd_t       q[$];
    int         phase = 0;      // 0 waiting, 1 fetching, 2 playing
    int         left  = 0;
    logic [1:0] exp_state  = 2'b11;
    logic       exp_busy   = 1'b0;
    logic       exp_done   = 1'b0;
    logic       exp_bumped = 1'b0;
    logic [$clog2(DEPTH):0] exp_level;
    int         n_vec = 0;
    int         n_err = 0;

    // One clock: check ready, advance model with the edge, check outputs.
    task automatic tick(output bit accepted);
        logic exp_ready, bump;
        cmd_t c, h;
        int   pre;
        #1;
        bump = 1'b0;
`ifdef WHEEL_SEQ_BUMPER_EN
        bump = bumper && (exp_state == 2'b00);
`endif
        exp_ready = (q.size() < DEPTH) && !abort && !rst && !bump;
        n_vec++;
        assert (cmd_bus.ready === exp_ready) else begin
            n_err++;
            $error("FAIL cmd_ready: observed %b expected %b t=%0t", cmd_bus.ready, exp_ready, $time);
        end
        accepted = cmd_bus.valid && exp_ready;
        c.dir = cmd_bus.dir;
        c.dur = int'(cmd_bus.dur);
        @(posedge clk);
        pre = q.size();
`ifdef WHEEL_SEQ_BUMPER_EN
        if (rst) exp_bumped = 1'b0;
        else if (bump) exp_bumped = 1'b1;
        else if (accepted) exp_bumped = 1'b0;
`endif
        if (rst || abort || bump) begin
            q.delete();
            phase = 0;
            left = 0;
            exp_state = 2'b11;
            exp_busy = 1'b0;
            exp_done = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (phase == 0) begin
                if (pre > 0) phase = 1;
            end else if (phase == 1) begin
                h = q.pop_front();
                if (h.dur == 0) begin
                    exp_done = 1'b1;
                    phase = (pre > 1) ? 1 : 0;
                end else begin
                    left = h.dur * PRESCALE;
                    exp_state = h.dir;
                    exp_busy = 1'b1;
                    phase = 2;
                end
            end else begin
                left--;
                if (left == 0) begin
                    exp_state = 2'b11;
                    exp_busy = 1'b0;
                    exp_done = 1'b1;
                    phase = (pre > 0) ? 1 : 0;
                end
            end
            if (accepted) q.push_back(c);
        end
        exp_level = ($clog2(DEPTH)+1)'(q.size());
        @(negedge clk);
        n_vec++;
        assert (state === exp_state) else begin
            n_err++;
            $error("FAIL state: observed %b expected %b t=%0t", state, exp_state, $time);
        end
        n_vec++;
        assert (busy === exp_busy) else begin
            n_err++;
            $error("FAIL busy: observed %b expected %b t=%0t", busy, exp_busy, $time);
        end
        n_vec++;
        assert (done === exp_done) else begin
            n_err++;
            $error("FAIL done: observed %b expected %b t=%0t", done, exp_done, $time);
        end
        n_vec++;
        assert (level === exp_level) else begin
            n_err++;
            $error("FAIL level: observed %0d expected %0d t=%0t", level, exp_level, $time);
        end
`ifdef WHEEL_SEQ_BUMPER_EN
        n_vec++;
        assert (bumped === exp_bumped) else begin
            n_err++;
            $error("FAIL bumped: observed %b expected %b t=%0t", bumped, exp_bumped, $time);
        end
`endif
    endtask

    task automatic run(input int n);
        bit acc;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    task automatic push(input logic [1:0] d, input int n);
        bit acc = 1'b0;
        cmd_bus.valid = 1'b1;
        cmd_bus.dir   = d;
        cmd_bus.dur   = DUR_W'(n);
        for (int i = 0; i < 300 && !acc; i++) tick(acc);
        if (!acc) begin
            n_err++;
            $error("FAIL push_timeout: observed no accept expected accept of dir %b dur %0d", d, n);
        end
        cmd_bus.valid = 1'b0;
    endtask

    initial begin
        bit acc;
        cmd_bus.valid = 1'b0;
        cmd_bus.dir   = 2'b00;
        cmd_bus.dur   = '0;

        // Reset, then ready in the first cycle after release
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        run(2);

        // Single forward command
        push(2'b00, 3);
        run(20);

        // Back-to-back including a zero-duration entry
        push(2'b01, 2);
        push(2'b10, 1);
        push(2'b00, 0);
        push(2'b11, 1);
        run(40);

        // Overfill while the first command runs
        push(2'b01, 3);
        push(2'b10, 1);
        push(2'b00, 2);
        push(2'b11, 1);
        push(2'b01, 1);
        push(2'b10, 2);
        run(100);

        // Abort mid-run with two queued and a command on offer
        push(2'b00, 3);
        push(2'b01, 1);
        push(2'b10, 1);
        run(4);
        cmd_bus.valid = 1'b1;
        cmd_bus.dir   = 2'b10;
        cmd_bus.dur   = DUR_W'(2);
        abort = 1'b1;
        tick(acc);
        abort = 1'b0;
        cmd_bus.valid = 1'b0;
        run(10);

`ifdef WHEEL_SEQ_BUMPER_EN
        push(2'b00, 5);
        run(6);
        bumper = 1'b1;
        tick(acc);
        bumper = 1'b0;
        run(3);
        push(2'b01, 2);
        run(3);
        bumper = 1'b1;
        run(3);
        bumper = 1'b0;
        run(10);
        push(2'b10, 1);
        run(10);
`endif

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cmd_bus.valid = 1'($urandom_range(0, 1));
            cmd_bus.dir   = 2'($urandom_range(0, 3));
            cmd_bus.dur   = DUR_W'($urandom_range(0, 3));
            abort         = ($urandom_range(0, 39) == 0);
            rst           = ($urandom_range(0, 249) == 0);
`ifdef WHEEL_SEQ_BUMPER_EN
            bumper        = ($urandom_range(0, 19) == 0);
`endif
            tick(acc);
        end
        cmd_bus.valid = 1'b0;
        abort = 1'b0;
        rst = 1'b0;
`ifdef WHEEL_SEQ_BUMPER_EN
        bumper = 1'b0;
`endif
        run(80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
